// File: rtl/transit_seq_pkg.sv
// rtl/transit_seq_pkg.sv - shared state type and constants for transit_dir_sequencer
package transit_seq_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic DIR_LTR = 1'b0;
  localparam logic DIR_RTL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FIRE,
    BLANK,
    CAPTURE,
    GAP
  } state_t;

endpackage

// File: rtl/transit_dir_sequencer_cycle_timer.sv
// rtl/transit_dir_sequencer_cycle_timer.sv - loadable saturating down-counter with done flag
module cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Loading N-1 on entry makes done rise in the Nth cycle of the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/transit_dir_sequencer.sv
// rtl/transit_dir_sequencer.sv - LTR/RTL transit shot sequencer with gated sample forwarding
// Optional capture watchdog enabled by macro TRANSIT_SEQ_TIMEOUT_EN.
module transit_dir_sequencer
  import transit_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 64,
  parameter int TX_CYCLES       = 16,
  parameter int BLANK_CYCLES    = 32,
  parameter int SAMPLES_PER_DIR = 256,
  parameter int GAP_CYCLES      = 1024,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid_out,
  output logic                dir,
  output logic                tx_en,
  output logic                busy,
  output logic                pair_done,
  output logic                timeout_err
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TX_LD     = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SAMPLES_PER_DIR - 1);

  state_t           state, state_nxt;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] smp_cnt;
  logic             accept, last_smp, wd_expire, aborted;
  logic             gap_exit, gap_to_arm;

  assign accept     = (state == CAPTURE) && sample_valid_in;
  assign last_smp   = accept && (smp_cnt == LAST_IDX);
  assign gap_exit   = (state == GAP) && tmr_done;
  // After a clean LTR shot the pair continues regardless of run.
  assign gap_to_arm = ((dir == DIR_LTR) && !aborted) || run;
  assign busy       = (state != IDLE);

  cycle_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef TRANSIT_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic wd_load, wd_done;

  assign wd_load   = (state == BLANK) && tmr_done;
  assign wd_expire = (state == CAPTURE) && wd_done && !last_smp;

  cycle_timer #(.CNT_W(CNT_W)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .load     (wd_load),
    .load_val (WD_LD),
    .done     (wd_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      aborted     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expire;
      if (wd_expire) begin
        aborted <= 1'b1;
      end else if (gap_exit) begin
        aborted <= 1'b0;
      end
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign aborted     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: begin
        if (run) begin
          state_nxt = ARM;
          tmr_load  = 1'b1;
          tmr_val   = SETTLE_LD;
        end
      end
      ARM: begin
        if (tmr_done) begin
          state_nxt = FIRE;
          tmr_load  = 1'b1;
          tmr_val   = TX_LD;
        end
      end
      FIRE: begin
        if (tmr_done) begin
          state_nxt = BLANK;
          tmr_load  = 1'b1;
          tmr_val   = BLANK_LD;
        end
      end
      BLANK: begin
        if (tmr_done) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (last_smp || wd_expire) begin
          state_nxt = GAP;
          tmr_load  = 1'b1;
          tmr_val   = GAP_LD;
        end
      end
      GAP: begin
        if (tmr_done) begin
          if (gap_to_arm) begin
            state_nxt = ARM;
            tmr_load  = 1'b1;
            tmr_val   = SETTLE_LD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir              <= DIR_LTR;
      tx_en            <= 1'b0;
      pair_done        <= 1'b0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      smp_cnt          <= '0;
    end else begin
      tx_en            <= (state_nxt == FIRE);
      sample_valid_out <= accept;
      if (accept) begin
        sample_out <= sample_in;
      end
      pair_done <= gap_exit && (dir == DIR_RTL) && !aborted;
      if (gap_exit) begin
        dir <= ((dir == DIR_LTR) && !aborted) ? DIR_RTL : DIR_LTR;
      end
      if (state != CAPTURE) begin
        smp_cnt <= '0;
      end else if (accept) begin
        smp_cnt <= smp_cnt + CNT_W'(1);
      end
    end
  end

endmodule
